// File: rtl/dualmem_port_arbiter.sv
// Round-robin arbiter and initialiser for one port of the 512-bit x 512-word line memory.
// Define DUALMEM_ARB_INIT_EN to zero-fill the memory after every reset before arbitration starts.
module dualmem_port_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*16-1:0]    req_we,
    input  logic [NREQ*9-1:0]     req_addr,
    input  logic [NREQ*512-1:0]   req_wdata,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [511:0]          rsp_rdata,
    output logic                  init_done,
    output logic [15:0]           mem_en,
    output logic [15:0]           mem_we,
    output logic [8:0]            mem_addr,
    output logic [511:0]          mem_din,
    input  logic [511:0]          mem_dout
);
    localparam int PW = $clog2(NREQ);

    // Handshake: a request transfers in any cycle where req_valid[i] && req_ready[i];
    // the requester holds valid/addr/mask/data stable until then. rsp_valid has no
    // backpressure and fires exactly one cycle after an accepted read.

    logic          init_busy;
    logic [8:0]    init_addr;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic [15:0]   gnt_we;
    logic [8:0]    gnt_addr;
    logic [511:0]  gnt_wdata;
    logic          xfer;
    logic          xfer_read;
    logic          rd_pend;
    logic [PW-1:0] rd_tag;

`ifdef DUALMEM_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t     state;
    state_t     state_next;
    logic [8:0] cnt;
    logic [8:0] cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == ST_INIT) begin
            cnt_next = cnt + 9'd1;
            if (cnt == 9'd511) begin
                state_next = ST_RUN;
            end
        end
    end

    assign init_busy = (state == ST_INIT);
    assign init_addr = cnt;
    assign init_done = (state == ST_RUN) && !rst;
`else
    assign init_busy = 1'b0;
    assign init_addr = '0;
    assign init_done = 1'b1;
`endif

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return PW'(sum);
    endfunction

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_valid[rr_index(ptr, i)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_index(ptr, i);
            end
        end
    end

    assign gnt_we    = req_we[gnt_idx*16 +: 16];
    assign gnt_addr  = req_addr[gnt_idx*9 +: 9];
    assign gnt_wdata = req_wdata[gnt_idx*512 +: 512];

    always_comb begin
        req_ready = '0;
        if (!rst && !init_busy && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer      = |req_ready;
    assign xfer_read = xfer && (gnt_we == 16'h0000);

    always_comb begin
        mem_en   = '0;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (!rst) begin
            if (init_busy) begin
                mem_en   = 16'hFFFF;
                mem_we   = 16'hFFFF;
                mem_addr = init_addr;
            end else if (gnt_any) begin
                mem_addr = gnt_addr;
                if (gnt_we == 16'h0000) begin
                    mem_en = 16'hFFFF;
                end else begin
                    mem_en  = gnt_we;
                    mem_we  = gnt_we;
                    mem_din = gnt_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            rd_pend <= 1'b0;
            rd_tag  <= '0;
        end else begin
            rd_pend <= xfer_read;
            if (xfer_read) begin
                rd_tag <= gnt_idx;
            end
            if (xfer) begin
                ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // The macro's output register supplies the data; the pending flag qualifies it,
    // and an asserted rst drops a response that would otherwise appear this cycle.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rd_pend && !rst) begin
            rsp_valid[rd_tag] = 1'b1;
            rsp_rdata         = mem_dout;
        end
    end

    a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready));
    a_rsp_onehot   : assert property (@(posedge clk) $onehot0(rsp_valid));
    a_ptr_range    : assert property (@(posedge clk) disable iff (rst) int'(ptr) < NREQ);

endmodule
